multiword_add_seq: RTL
======================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits processed per cycle (slice width).
REQ-002 SHALL have parameter WORDS, default 4: number of slices per operand, minimum 1; total operand width N = WIDTH*WORDS.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request a new operation; sampled on clk.
REQ-006 SHALL have port sub  input  1  operation select, sampled with start: 0 = a+b+cin, 1 = a-b.
REQ-007 SHALL have port abort  input  1  cancel the operation in progress.
REQ-008 SHALL have port a  input  N  first operand, sampled with start.
REQ-009 SHALL have port b  input  N  second operand, sampled with start.
REQ-010 SHALL have port cin  input  1  carry-in for add, sampled with start; ignored when sub=1.
REQ-011 SHALL have port busy  output  1  high while slices are being processed.
REQ-012 SHALL have port done  output  1  one-cycle pulse when sum/cout are updated.
REQ-013 SHALL have port sum  output  N  registered result of the last completed operation.
REQ-014 SHALL have port cout  output  1  registered carry-out of the last completed operation; for sub, 1 = no borrow.

Function
REQ-015 SHALL implement states IDLE, RUN and DONE.
REQ-016 SHALL accept start only in IDLE or DONE; on the accepting edge it SHALL latch a, b and sub, set slice index idx=0, load carry register with (sub ? 1 : cin), and enter RUN.
REQ-017 SHALL, when sub=1, use the bitwise inverse of b, so the result is a + ~b + 1.
REQ-018 SHALL, on each RUN edge, add slice idx of a to slice idx of (possibly inverted) b plus the carry register through one WIDTH-bit adder.
REQ-019 SHALL, on each RUN edge, write the adder result into slice idx of an internal accumulator, store the adder carry-out in the carry register, and increment idx.
REQ-020 SHALL, on the RUN edge with idx==WORDS-1, load sum from the accumulator (including that final slice) and cout from the final carry, then enter DONE.
REQ-021 SHALL therefore spend exactly WORDS edges in RUN, with done high in the cycle beginning WORDS edges after the start edge.
REQ-022 SHALL hold done high for exactly one cycle (state DONE). DONE SHALL go to IDLE on the next edge, or to RUN if start=1 on that edge, giving back-to-back operation.
REQ-023 SHALL drive busy=1 only in RUN.
REQ-024 SHALL ignore start in RUN; the operation continues unaffected.
REQ-025 SHALL, on abort=1 in RUN, return to IDLE on that edge with no done, leaving sum and cout unchanged.
REQ-026 SHALL ignore abort in IDLE and DONE; start together with abort in IDLE or DONE SHALL be accepted.
REQ-027 SHALL update sum and cout only on completion; they SHALL hold between operations.
REQ-028 SHALL apply modulo-2^N arithmetic; overflow appears only on cout.
REQ-029 SHALL, with WORDS=1, complete in a single RUN edge.

Reset
REQ-030 SHALL, on rst=1 at a clk edge (taking priority over all inputs, including mid-operation), set state=IDLE, idx=0, carry register=0, accumulator=0, sum=0, cout=0, busy=0 and done=0.

Structure
REQ-031 SHALL take the state enum and an index-width helper (clog2 of WORDS, minimum 1) from shared package multiword_add_pkg.
REQ-032 SHALL instantiate one sub-module, slice_adder: combinational WIDTH-bit ripple adder with ports a, b, cin, sum and cout, built as a generate loop of one-bit full-adder cells.
REQ-033 SHALL place no other arithmetic on the datapath.

Verification (WIDTH=4, WORDS=4)
REQ-034 SHALL cover: start with a=0x00FF, b=0x0001, cin=0, sub=0 -> busy for 4 cycles, then done pulse with sum=0x0100, cout=0.
REQ-035 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; repeat with cin=1 and b=0x0000 -> sum=0x0000, cout=1.
REQ-036 SHALL cover: sub=1, a=0x1234, b=0x1235 -> sum=0xFFFF, cout=0; then a=0x1235, b=0x1234 -> sum=0x0001, cout=1.
REQ-037 SHALL cover: abort on the 2nd RUN cycle after a prior result of 0x0100 -> no done, busy falls, sum stays 0x0100; a start with new operands during RUN is ignored.
REQ-038 SHALL cover: start asserted in the DONE cycle -> new operation runs back-to-back with its done exactly 4 edges later.
REQ-039 SHALL cover: rst during RUN -> next cycle state IDLE with all outputs 0.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the sequential multiword adder.
// Provides the controller state enum and the slice-index width helper.
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that indexes WORDS slices, never below one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_seq_slice_adder.sv
// slice_adder: combinational WIDTH-bit ripple-carry adder.
// Ports: a, b (WIDTH) operands; cin carry-in; sum (WIDTH); cout carry-out.
module slice_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential N-bit add/subtract that processes one WIDTH-bit slice per cycle.
// Ports: clk, rst (sync, active-high); start/sub/abort/a/b/cin requests;
// busy, done (one-cycle pulse), sum (N), cout (1 = no borrow for sub).
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   abort,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout
);

    localparam int N  = WIDTH * WORDS;
    localparam int IW = idx_width(WORDS);

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    a_q,     a_d;
    logic [N-1:0]    b_q,     b_d;
    logic [N-1:0]    acc_q,   acc_d;
    logic [N-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [WIDTH-1:0] sl_a;
    logic [WIDTH-1:0] sl_b;
    logic [WIDTH-1:0] sl_s;
    logic             sl_c;

    // b_q already holds ~b for subtraction, so the slice path is add-only.
    assign sl_a = a_q[idx_q*WIDTH +: WIDTH];
    assign sl_b = b_q[idx_q*WIDTH +: WIDTH];

    slice_adder #(
        .WIDTH (WIDTH)
    ) u_slice_adder (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_s),
        .cout (sl_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d[idx_q*WIDTH +: WIDTH] = sl_s;
                    carry_d = sl_c;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        // acc_d already contains the final slice.
                        sum_d   = acc_d;
                        cout_d  = sl_c;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
